// File: rtl/sample_path_pkg.sv
// Shared definitions for the sample path: default word width and the
// arbiter owner-state encodings.
package sample_path_pkg;

   localparam int DEFAULT_DATA_W = 32;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   function automatic logic [1:0] owner_of(input logic ch);
      return ch ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/mux2.sv
// Generic 2:1 word multiplexer: o = s ? i2 : i1.
module mux2 #(
   parameter int W = 32
) (
   input  logic [W-1:0] i1,
   input  logic [W-1:0] i2,
   input  logic         s,
   output logic [W-1:0] o
);

   assign o = s ? i2 : i1;

endmodule

// File: rtl/sample_stream_arbiter.sv
// Two-channel round-robin arbiter with a per-grant burst limit, feeding a
// one-entry output register on the shared sample path.
module sample_stream_arbiter
   import sample_path_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in0_valid,
   input  logic [DATA_W-1:0] in0_data,
   output logic              in0_ready,
   input  logic              in1_valid,
   input  logic [DATA_W-1:0] in1_data,
   output logic              in1_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
   input  logic              out_ready
);

   localparam int               CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

   logic [1:0]        owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_src_q, out_src_d;

   logic              gnt_any, gnt_ch;
   logic              burst_done, space, accept;
   logic [DATA_W-1:0] sel_data;

   assign burst_done = (cnt_q >= CNT_MAX);
   assign space      = !out_valid_q || out_ready;

   always_comb begin
      // NOTE: defaults first so every path assigns both signals and no latch is inferred.
      gnt_any = 1'b0;
      gnt_ch  = 1'b0;
      case (owner_q)
         OWN0: begin
            if (in0_valid && (!burst_done || !in1_valid)) begin
               gnt_any = 1'b1;
               gnt_ch  = 1'b0;
            end else if (in1_valid) begin
               gnt_any = 1'b1;
               gnt_ch  = 1'b1;
            end
         end
         OWN1: begin
            if (in1_valid && (!burst_done || !in0_valid)) begin
               gnt_any = 1'b1;
               gnt_ch  = 1'b1;
            end else if (in0_valid) begin
               gnt_any = 1'b1;
               gnt_ch  = 1'b0;
            end
         end
         default: begin
            // Idle tie-break favours the channel not served last.
            if (in0_valid && (!in1_valid || last_q)) begin
               gnt_any = 1'b1;
               gnt_ch  = 1'b0;
            end else if (in1_valid) begin
               gnt_any = 1'b1;
               gnt_ch  = 1'b1;
            end
         end
      endcase
   end

   assign in0_ready = rst_n && gnt_any && !gnt_ch && space;
   assign in1_ready = rst_n && gnt_any &&  gnt_ch && space;
   assign accept    = gnt_any && space && (gnt_ch ? in1_valid : in0_valid);

   mux2 #(.W(DATA_W)) u_sel_mux (
      .i1 (in0_data),
      .i2 (in1_data),
      .s  (gnt_any && gnt_ch),
      .o  (sel_data)
   );

   always_comb begin
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (accept) begin
         out_data_d  = sel_data;
         out_src_d   = gnt_ch;
         out_valid_d = 1'b1;
         owner_d     = owner_of(gnt_ch);
         last_d      = gnt_ch;
         if (owner_q == owner_of(gnt_ch)) begin
            cnt_d = burst_done ? cnt_q : cnt_q + 1'b1;
         end else begin
            cnt_d = CNT_W'(1);
         end
      end else begin
         if (out_ready) begin
            out_valid_d = 1'b0;
         end
         if (!in0_valid && !in1_valid) begin
            owner_d = IDLE;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q     <= IDLE;
         cnt_q       <= '0;
         last_q      <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values together.
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_sample_stream_arbiter.sv
// Randomised and directed bench for sample_stream_arbiter against a
// behavioural round-robin model with an end-to-end word scoreboard.
module tb_sample_stream_arbiter;

   localparam int DW = 32;
   localparam int MB = 4;

   logic          clk, rst_n;
   logic          in0_valid, in0_ready, in1_valid, in1_ready;
   logic [DW-1:0] in0_data, in1_data;
   logic          out_valid, out_src, out_ready;
   logic [DW-1:0] out_data;

   sample_stream_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          src;
      logic [DW-1:0] data;
   } beat_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Producer queues (word at the head is presented while pvX is set).
   logic [DW-1:0] q0[$], q1[$];
   bit            pv0, pv1;
   // Words the DUT accepted and has not yet delivered downstream.
   logic [DW-1:0] sent0[$], sent1[$];
   beat_t         trace[$];

   // Behavioural model: owner -1 = nobody, run = beats in current grant.
   int            m_owner, m_run, m_last;
   bit            m_ov, m_os;
   logic [DW-1:0] m_od;

   // Values observed in the most recent cycle, for directed checks.
   logic          s_r0, s_r1, s_ov;
   logic [DW-1:0] s_od;
   bit            seen_r1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_run   = 0;
      m_last  = 1;
      m_ov    = 1'b0;
      m_os    = 1'b0;
      m_od    = '0;
   endtask

   function automatic int model_grant(input bit v0, input bit v1);
      bit vk, vo;
      if (m_owner < 0) begin
         if (v0 && (!v1 || m_last == 1)) return 0;
         if (v1) return 1;
         return -1;
      end
      vk = (m_owner == 1) ? v1 : v0;
      vo = (m_owner == 1) ? v0 : v1;
      if (vk && (m_run < MB || !vo)) return m_owner;
      if (vo) return 1 - m_owner;
      return -1;
   endfunction

   task automatic cycle(input int p0, input int p1, input int pr);
      int            g;
      bit            sp, v0, v1, r, cons, c_src, acc0, acc1;
      logic [DW-1:0] d0, d1, c_data;
      @(negedge clk);
      if (!pv0 && q0.size() > 0 && int'($urandom_range(99)) < p0) pv0 = 1'b1;
      if (!pv1 && q1.size() > 0 && int'($urandom_range(99)) < p1) pv1 = 1'b1;
      in0_valid = pv0;
      in0_data  = pv0 ? q0[0] : $urandom();
      in1_valid = pv1;
      in1_data  = pv1 ? q1[0] : $urandom();
      out_ready = (int'($urandom_range(99)) < pr);
      #1;
      v0 = in0_valid; v1 = in1_valid; d0 = in0_data; d1 = in1_data; r = out_ready;
      g  = model_grant(v0, v1);
      sp = !m_ov || r;
      check("in0_ready", 32'(in0_ready), 32'((g == 0) && sp));
      check("in1_ready", 32'(in1_ready), 32'((g == 1) && sp));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
         check("out_data", out_data, m_od);
         check("out_src", 32'(out_src), 32'(m_os));
      end
      s_r0 = in0_ready; s_r1 = in1_ready; s_ov = out_valid; s_od = out_data;
      if (in1_ready) seen_r1 = 1'b1;
      cons   = out_valid && out_ready;
      c_src  = out_src;
      c_data = out_data;
      acc0   = in0_valid && in0_ready;
      acc1   = in1_valid && in1_ready;
      @(posedge clk);
      if (cons) begin
         trace.push_back('{src: c_src, data: c_data});
         if (c_src) begin
            check("sb_depth1", 32'(sent1.size()), 32'd1);
            if (sent1.size() > 0) check("sb_data1", c_data, sent1.pop_front());
         end else begin
            check("sb_depth0", 32'(sent0.size()), 32'd1);
            if (sent0.size() > 0) check("sb_data0", c_data, sent0.pop_front());
         end
      end
      if (acc0) begin sent0.push_back(d0); void'(q0.pop_front()); pv0 = 1'b0; end
      if (acc1) begin sent1.push_back(d1); void'(q1.pop_front()); pv1 = 1'b0; end
      if (g >= 0 && sp) begin
         m_od    = (g == 1) ? d1 : d0;
         m_os    = (g == 1);
         m_ov    = 1'b1;
         m_run   = (m_owner == g) ? m_run + 1 : 1;
         m_owner = g;
         m_last  = g;
      end else begin
         if (r) m_ov = 1'b0;
         if (!v0 && !v1) begin m_owner = -1; m_run = 0; end
      end
   endtask

   task automatic drain(input int p0, input int p1, input int pr, output int n);
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || m_ov) && n < 3000) begin
         cycle(p0, p1, pr);
         n++;
      end
      check("drain_done", 32'(q0.size() + q1.size() + int'(m_ov)), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_src", 32'(out_src), 32'd0);
      check("rst_in0_ready", 32'(in0_ready), 32'd0);
      check("rst_in1_ready", 32'(in1_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      sent0.delete();
      sent1.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n, k0, k1, e;
      rst_n = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
      in0_data = '0; in1_data = '0; out_ready = 1'b0;
      pv0 = 1'b0; pv1 = 1'b0; seen_r1 = 1'b0;
      model_reset();
      do_reset();

      // Contention: alternating runs of MB beats, no bubbles.
      trace.delete();
      for (int i = 0; i < 12; i++) begin
         q0.push_back(32'(32'h100 + i));
         q1.push_back(32'(32'h200 + i));
      end
      drain(100, 100, 100, n);
      check("cont_cycles", 32'(n), 32'd25);
      check("cont_len", 32'(trace.size()), 32'd24);
      k0 = 0; k1 = 0;
      for (int i = 0; i < trace.size(); i++) begin
         e = (i / 4) % 2;
         check("cont_src", 32'(trace[i].src), 32'(e));
         if (e == 1) begin check("cont_data", trace[i].data, 32'(32'h200 + k1)); k1++; end
         else        begin check("cont_data", trace[i].data, 32'(32'h100 + k0)); k0++; end
      end

      // Single channel stream 1..8.
      trace.delete(); seen_r1 = 1'b0;
      for (int i = 1; i <= 8; i++) q0.push_back(32'(i));
      drain(100, 100, 100, n);
      check("single_cycles", 32'(n), 32'd9);
      check("single_len", 32'(trace.size()), 32'd8);
      for (int i = 0; i < trace.size(); i++) begin
         check("single_data", trace[i].data, 32'(i + 1));
         check("single_src", 32'(trace[i].src), 32'd0);
      end
      check("single_no_r1", 32'(seen_r1), 32'd0);

      // Backpressure on 0xDEADBEEF.
      trace.delete();
      q0.push_back(32'hDEADBEEF); q0.push_back(32'd2); q0.push_back(32'd3);
      cycle(100, 100, 100);
      for (int i = 0; i < 3; i++) begin
         cycle(100, 100, 0);
         check("bp_valid", 32'(s_ov), 32'd1);
         check("bp_data", s_od, 32'hDEADBEEF);
         check("bp_r0", 32'(s_r0), 32'd0);
         check("bp_r1", 32'(s_r1), 32'd0);
      end
      drain(100, 100, 100, n);
      check("bp_len", 32'(trace.size()), 32'd3);
      check("bp_w0", trace[0].data, 32'hDEADBEEF);
      check("bp_w1", trace[1].data, 32'd2);
      check("bp_w2", trace[2].data, 32'd3);

      // Idle tie-break, ch1 served last then ch0 served last.
      q1.push_back(32'h11);
      drain(100, 100, 100, n);
      cycle(100, 100, 100); cycle(100, 100, 100);
      trace.delete();
      q0.push_back(32'hA0); q1.push_back(32'hA1);
      drain(100, 100, 100, n);
      check("tie1_src", 32'(trace[0].src), 32'd0);
      check("tie1_data", trace[0].data, 32'hA0);
      q0.push_back(32'h22);
      drain(100, 100, 100, n);
      cycle(100, 100, 100); cycle(100, 100, 100);
      trace.delete();
      q0.push_back(32'hB0); q1.push_back(32'hB1);
      drain(100, 100, 100, n);
      check("tie0_src", 32'(trace[0].src), 32'd1);
      check("tie0_data", trace[0].data, 32'hB1);

      // Lone requester beyond the burst limit, then ch0 joins.
      trace.delete();
      for (int i = 0; i < 14; i++) q1.push_back(32'(32'h300 + i));
      for (int i = 0; i < 10; i++) begin
         cycle(100, 100, 100);
         check("lone_r1", 32'(s_r1), 32'd1);
      end
      q0.push_back(32'h400);
      cycle(100, 100, 100);
      check("lone_join_r0", 32'(s_r0), 32'd1);
      check("lone_join_r1", 32'(s_r1), 32'd0);
      drain(100, 100, 100, n);
      check("lone_join_src", 32'(trace[10].src), 32'd0);
      check("lone_join_data", trace[10].data, 32'h400);

      // Randomised traffic with varying rates and backpressure.
      for (int i = 0; i < 300; i++) begin q0.push_back($urandom()); q1.push_back($urandom()); end
      for (int ph = 0; ph < 6; ph++) begin
         int a, b, c;
         a = int'($urandom_range(100, 20));
         b = int'($urandom_range(100, 20));
         c = int'($urandom_range(100, 15));
         for (int i = 0; i < 200; i++) cycle(a, b, c);
      end
      drain(70, 70, 80, n);

      // Reset mid-traffic, then both valid after release.
      for (int i = 0; i < 20; i++) begin q0.push_back($urandom()); q1.push_back($urandom()); end
      for (int i = 0; i < 7; i++) cycle(100, 100, 50);
      do_reset();
      trace.delete();
      drain(100, 100, 100, n);
      check("rst_any", 32'(trace.size() > 0), 32'd1);
      check("rst_first_src", 32'(trace[0].src), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_stream_arbiter.md
# sample_stream_arbiter

Two-requester round-robin arbiter that shares one 32-bit sample path between two valid/ready producers, for example the ECG acquisition stream and a test-pattern or replay stream. It chooses the source for the 2:1 data select each cycle and enforces a burst limit per grant. The selected word goes into a one-entry output register that drives the downstream filter stage with zero-bubble throughput.

## Interface
- DATA_W, 32, sample width.
- MAX_BURST, 4, maximum consecutive beats per grant while the other channel waits; must be ≥1.
- CNT_W, $clog2(MAX_BURST+1), burst counter width; derived, do not override.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in0_valid  in  1  channel 0 has a word.
- in0_data  in  DATA_W  channel 0 word.
- in0_ready  out  1  channel 0 word accepted this cycle.
- in1_valid, in1_data, in1_ready: same roles for channel 1.
- out_valid  out  1  output register holds a word.
- out_data  out  DATA_W  registered word.
- out_src  out  1  channel that produced out_data.
- out_ready  in  1  downstream accepts out_data.

## Operation
- Producer rule: once valid is high, the producer holds valid and data stable until ready is high. The arbiter relies on this rule and does not check it.
- State registers:
  - owner, one of IDLE, OWN0, OWN1.
  - cnt, CNT_W bits: beats in the current grant.
  - last, 1 bit: last channel served.
- Combinational grant g (none, 0 or 1):
  - IDLE: grant 0 if in0_valid and (!in1_valid or last==1). Otherwise grant 1 if in1_valid. Otherwise none.
  - OWNk: grant k if ink_valid and (cnt<MAX_BURST or the other channel is not valid). Otherwise grant the other channel if it is valid. Otherwise none.
- space = !out_valid || out_ready.
- ink_ready = (g==k) && space. Only one ready can be high in a cycle.
- Accept: a beat is accepted when the granted channel's valid and ready are both high.
- On accept from channel g:
  - out_data ← in_g data, out_src ← g, out_valid ← 1.
  - owner ← OWNg, last ← g.
  - cnt ← cnt+1 (saturating at MAX_BURST) if owner was already OWNg; otherwise cnt ← 1.
- No accept and out_ready high: out_valid ← 0.
- No accept and out_valid high with out_ready low: out_valid and out_data are held.
- Neither input valid: owner ← IDLE, cnt ← 0, last is kept.
- Stall (some input valid, space low): owner, cnt and last are held. The grant is re-evaluated combinationally every cycle.
- Single requester: it is never starved by the burst limit. cnt saturates and beats keep flowing.
- Both valid continuously: the source alternates in runs of exactly MAX_BURST beats.

## Timing
- Reset values, forced immediately while rst_n is low:
  - out_valid=0, out_data=0, out_src=0.
  - owner=IDLE, cnt=0, last=1, so channel 0 wins the first tie.
  - in0_ready and in1_ready are 0 while rst_n is low.
- Latency: a word accepted at edge N appears on out_data after edge N. That is one cycle, with no extra arbitration cycle.
- Throughput: one beat per cycle while out_ready is held high.
- Backpressure: out_ready low with out_valid high gives in0_ready=in1_ready=0 in the same cycle. No word is lost or duplicated.
- Reset asserted mid-burst: an in-flight out_data word is discarded. After release, arbitration restarts from IDLE with channel 0 preferred.

## Structure
- Shared package (sample_path_pkg):
  - DATA_W default.
  - owner state encodings IDLE=2'd0, OWN0=2'd1, OWN1=2'd2.
- Sub-module: one instance of the codebase's 32-bit 2:1 mux (mux2), with i1=in0_data, i2=in1_data, s=(g==1), feeding the out_data register.
- Grant logic, counters and the output register stay in this module.

## Test plan
- Reset: drive rst_n=0 mid-traffic → out_valid=0, out_data=0, both readies 0 asynchronously. After release with both inputs valid, the first out_src is 0.
- Single channel: in0 streams 0x00000001..0x00000008 with out_ready=1 → 8 consecutive outputs in order, out_src=0, first output one cycle after the first accept. in1_ready stays 0.
- Contention, MAX_BURST=4: both inputs valid continuously → out_src sequence 0,0,0,0,1,1,1,1,0,… with no idle cycles.
- Backpressure: out_data=0xDEADBEEF and out_ready low for 3 cycles → out_data held, both readies 0. After release each word is seen exactly once.
- Idle tie-break: ch1 served last, then both inputs idle, then both valid in the same cycle → ch0 is granted first. Repeat with ch0 served last → ch1 is granted first.
- Lone requester past the limit: only in1 valid for 10 beats → 10 contiguous grants to ch1, cnt saturated at 4. When in0 then asserts, it is granted on the next beat.
